lsu_amo_unit: RTL and testbench
===============================

// Module: lsu_amo_unit
// PURPOSE
// Parametrised execute-phase load/store unit with full RV-A atomic support: LB/LH/LW(/LD), stores,
// LR/SC with a one-entry reservation, and the nine AMO read-modify-write ops.
// Sits between the CPU control FSM (valid/ready request, one-cycle response pulse) and the
// single-master memory bus (o_bus_DV / i_input_bus_DV handshake).
// Adds misalignment detection, illegal-op reporting and a bus timeout watchdog.
// PARAMETERS
// XLEN         32  data/address width; 32 or 64 only
// TIMEOUT_CYC  0   bus wait cycles before error; 0 disables the watchdog
// LRSC_EN      1   0: LR/SC are reported as illegal
// PORTS
// i_clk             in   1     clock, rising edge
// i_rst_n           in   1     asynchronous active-low reset
// i_req_valid       in   1     request present
// o_req_ready       out  1     unit accepts a request (state IDLE)
// i_req_op          in   4     0 LD,1 ST,2 LR,3 SC,4 SWAP,5 ADD,6 XOR,7 AND,8 OR,9 MIN,10 MAX,11 MINU,12 MAXU
// i_req_size        in   2     00 byte, 01 half, 10 word, 11 dword (XLEN=64 only)
// i_req_signed      in   1     sign-extend load result (LD only)
// i_req_addr        in   XLEN  effective address (base+offset already added)
// i_req_wdata       in   XLEN  store data / AMO operand, right-aligned
// o_rsp_valid       out  1     one-cycle response pulse
// o_rsp_data        out  XLEN  load value / AMO old value / SC result (0 ok, 1 fail)
// o_rsp_err         out  2     00 ok, 01 misaligned, 10 illegal op/size, 11 bus timeout
// o_bhw             out  4     one-hot size: 0001 B, 0010 H, 0100 W, 1000 D
// o_bus_address     out  XLEN  bus address
// o_bus_data        out  XLEN  bus write data, right-aligned
// o_bus_DV          out  1     one-cycle bus command strobe
// o_write_notread   out  1     1 write, 0 read
// i_input_bus_DV    in   1     bus completion strobe (read data or write ack)
// i_input_bus_data  in   XLEN  read data, right-aligned
// BEHAVIOUR
// - Reset (async, i_rst_n=0): all outputs 0, state IDLE, reservation invalid, timeout counter 0.
// - States: IDLE, RD_WAIT, WR_ISSUE, WR_WAIT. o_req_ready = (state==IDLE). Handshake = valid&ready.
// - Accept at edge N: legal access -> o_bus_DV=1 for cycle N+1 with addr/bhw/data/write_notread;
//   bus fields hold until next command. LD/LR/AMO -> RD_WAIT; ST/SC-pass -> WR_WAIT.
// - Checks at accept, priority illegal > misaligned: op>12, size 11 with XLEN=32, LR/SC with LRSC_EN=0,
//   LR/SC/AMO size not W/D -> err 10; H addr[0]!=0, W addr[1:0]!=0, D addr[2:0]!=0 -> err 01.
//   Error: no bus command, o_rsp_valid at N+1, o_rsp_data=0, state stays IDLE.
// - RD_WAIT + i_input_bus_DV at edge M: LD/LR respond at M+1 with data zero/sign-extended from size;
//   LR also sets reservation {valid, addr}. AMO latches old value, goes WR_ISSUE.
// - WR_ISSUE: o_bus_DV write of f(old,wdata) one cycle; -> WR_WAIT. MIN/MAX signed, MINU/MAXU unsigned;
//   ADD wraps mod 2^size; W ops on XLEN=64 operate on low 32 bits, result sign-extended.
// - WR_WAIT + i_input_bus_DV: respond next cycle; data = old value (AMO), 0 (ST, SC-pass).
// - SC: pass iff reservation valid and addr matches; fail -> no bus, rsp_data=1 at N+1. Every SC clears
//   the reservation. ST/AMO to reserved address (XLEN-aligned match) clears it.
// - o_rsp_valid asserts with state already IDLE, so a new request may be accepted in that same cycle.
// - Timeout: counter resets on each entry to a wait state; at TIMEOUT_CYC wait cycles without
//   i_input_bus_DV -> rsp err 11, data 0, IDLE; AMO timeout in WR_WAIT leaves memory state undefined.
// - i_input_bus_DV outside RD_WAIT/WR_WAIT is ignored. Reset mid-op aborts with no response.
// TESTING
// - LB addr 0x103, bus returns 0x000000F0 -> rsp_data 0xFFFFFFF0, bhw 0001, 1 bus read, err 00.
// - SH addr 0x201 -> rsp err 01 next cycle, o_bus_DV never asserted.
// - AMOMAX W addr 0x40, mem 0xFFFFFFFE, wdata 5 -> write 5 to 0x40, rsp_data 0xFFFFFFFE.
// - LR 0x80, then SC 0x80 wdata 7 -> write, rsp 0; second SC 0x80 -> rsp 1, no bus activity.
// - TIMEOUT_CYC=8, LW with no bus reply -> rsp err 11 exactly 8 cycles after entering RD_WAIT.
// - Reset asserted in WR_WAIT of AMOADD -> outputs 0, o_req_ready=1, late i_input_bus_DV ignored.

Source files
------------

// File: rtl/lsu_amo_unit.sv
// Execute-phase load/store unit with RV-A atomics, a one-entry LR/SC reservation and a bus watchdog.
// One access in flight at a time; bus commands and responses are registered outputs.
module lsu_amo_unit #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 0,
  parameter bit LRSC_EN     = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [3:0]      i_req_op,
  input  logic [1:0]      i_req_size,
  input  logic            i_req_signed,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_rsp_valid,
  output logic [XLEN-1:0] o_rsp_data,
  output logic [1:0]      o_rsp_err,
  output logic [3:0]      o_bhw,
  output logic [XLEN-1:0] o_bus_address,
  output logic [XLEN-1:0] o_bus_data,
  output logic            o_bus_DV,
  output logic            o_write_notread,
  input  logic            i_input_bus_DV,
  input  logic [XLEN-1:0] i_input_bus_data
);

  localparam logic [3:0] OP_LD   = 4'd0;
  localparam logic [3:0] OP_ST   = 4'd1;
  localparam logic [3:0] OP_LR   = 4'd2;
  localparam logic [3:0] OP_SC   = 4'd3;
  localparam logic [3:0] OP_SWAP = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_MIN  = 4'd9;
  localparam logic [3:0] OP_MAX  = 4'd10;
  localparam logic [3:0] OP_MINU = 4'd11;
  localparam logic [3:0] OP_MAXU = 4'd12;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int AW = $clog2(XLEN / 8);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ISSUE, WR_WAIT} state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [1:0]      size_q, size_d;
  logic            signed_q, signed_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] old_q, old_d;
  logic            resvValid_q, resvValid_d;
  logic [XLEN-1:0] resvAddr_q, resvAddr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            rspValid_q, rspValid_d;
  logic [XLEN-1:0] rspData_q, rspData_d;
  logic [1:0]      rspErr_q, rspErr_d;
  logic [3:0]      bhw_q, bhw_d;
  logic [XLEN-1:0] busAddr_q, busAddr_d;
  logic [XLEN-1:0] busData_q, busData_d;
  logic            busDv_q, busDv_d;
  logic            busWe_q, busWe_d;

  function automatic logic [XLEN-1:0] sext8(input logic [7:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic reqIsLrSc, reqIsAmo, reqIllegal, reqMisaligned, reqScPass, reqLineHit, timeoutHit;

  always_comb begin
    reqIsLrSc     = (i_req_op == OP_LR) || (i_req_op == OP_SC);
    reqIsAmo      = (i_req_op >= OP_SWAP) && (i_req_op <= OP_MAXU);
    reqIllegal    = (i_req_op > OP_MAXU)
                 || ((XLEN == 32) && (i_req_size == SZ_D))
                 || (reqIsLrSc && !LRSC_EN)
                 || ((reqIsLrSc || reqIsAmo) && !i_req_size[1]);
    reqMisaligned = 1'b0;
    case (i_req_size)
      SZ_H:    reqMisaligned = i_req_addr[0];
      SZ_W:    reqMisaligned = |i_req_addr[1:0];
      SZ_D:    reqMisaligned = |i_req_addr[2:0];
      default: reqMisaligned = 1'b0;
    endcase
    reqScPass  = resvValid_q && (resvAddr_q == i_req_addr);
    reqLineHit = resvValid_q && (resvAddr_q[XLEN-1:AW] == i_req_addr[XLEN-1:AW]);
    timeoutHit = (TIMEOUT_CYC > 0) && (timer_q == TLAST);
  end

  // Loads extend from the access size; LR always sign-extends like RV LR.W/LR.D.
  logic            loadSext;
  logic [XLEN-1:0] loadData;

  always_comb begin
    loadSext = signed_q || (op_q == OP_LR);
    case (size_q)
      SZ_B:    loadData = loadSext ? sext8(i_input_bus_data[7:0])   : XLEN'(i_input_bus_data[7:0]);
      SZ_H:    loadData = loadSext ? sext16(i_input_bus_data[15:0]) : XLEN'(i_input_bus_data[15:0]);
      SZ_W:    loadData = loadSext ? sext32(i_input_bus_data[31:0]) : XLEN'(i_input_bus_data[31:0]);
      default: loadData = i_input_bus_data;
    endcase
  end

  // Word AMOs work on the low 32 bits: signed ops see sign-extended operands, unsigned ops zero-extended.
  logic [XLEN-1:0] amoA, amoB, amoAu, amoBu, amoRaw, amoResult, oldRet;

  always_comb begin
    if (size_q == SZ_W) begin
      amoA  = sext32(old_q[31:0]);
      amoB  = sext32(wdata_q[31:0]);
      amoAu = XLEN'(old_q[31:0]);
      amoBu = XLEN'(wdata_q[31:0]);
    end else begin
      amoA  = old_q;
      amoB  = wdata_q;
      amoAu = old_q;
      amoBu = wdata_q;
    end
    case (op_q)
      OP_SWAP: amoRaw = amoB;
      OP_ADD:  amoRaw = amoA + amoB;
      OP_XOR:  amoRaw = amoA ^ amoB;
      OP_AND:  amoRaw = amoA & amoB;
      OP_OR:   amoRaw = amoA | amoB;
      OP_MIN:  amoRaw = ($signed(amoA) < $signed(amoB)) ? amoA : amoB;
      OP_MAX:  amoRaw = ($signed(amoA) > $signed(amoB)) ? amoA : amoB;
      OP_MINU: amoRaw = (amoAu < amoBu) ? amoA : amoB;
      OP_MAXU: amoRaw = (amoAu > amoBu) ? amoA : amoB;
      default: amoRaw = amoB;
    endcase
    amoResult = (size_q == SZ_W) ? sext32(amoRaw[31:0]) : amoRaw;
    oldRet    = (size_q == SZ_W) ? sext32(old_q[31:0])  : old_q;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    old_d       = old_q;
    resvValid_d = resvValid_q;
    resvAddr_d  = resvAddr_q;
    timer_d     = timer_q;
    rspValid_d  = 1'b0;
    rspData_d   = '0;
    rspErr_d    = 2'b00;
    bhw_d       = bhw_q;
    busAddr_d   = busAddr_q;
    busData_d   = busData_q;
    busDv_d     = 1'b0;
    busWe_d     = busWe_q;

    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          op_d     = i_req_op;
          size_d   = i_req_size;
          signed_d = i_req_signed;
          addr_d   = i_req_addr;
          wdata_d  = i_req_wdata;
          if (i_req_op == OP_SC) resvValid_d = 1'b0;
          if (reqIllegal) begin
            rspValid_d = 1'b1;
            rspErr_d   = 2'b10;
          end else if (reqMisaligned) begin
            rspValid_d = 1'b1;
            rspErr_d   = 2'b01;
          end else if ((i_req_op == OP_SC) && !reqScPass) begin
            rspValid_d = 1'b1;
            rspData_d  = XLEN'(1);
          end else begin
            busDv_d   = 1'b1;
            busAddr_d = i_req_addr;
            busData_d = i_req_wdata;
            bhw_d     = 4'b0001 << i_req_size;
            timer_d   = '0;
            if ((i_req_op == OP_ST) || (i_req_op == OP_SC)) begin
              busWe_d = 1'b1;
              state_d = WR_WAIT;
            end else begin
              busWe_d = 1'b0;
              state_d = RD_WAIT;
            end
            if (((i_req_op == OP_ST) || reqIsAmo) && reqLineHit) resvValid_d = 1'b0;
          end
        end
      end

      RD_WAIT: begin
        if (i_input_bus_DV) begin
          if ((op_q >= OP_SWAP) && (op_q <= OP_MAXU)) begin
            old_d   = i_input_bus_data;
            state_d = WR_ISSUE;
          end else begin
            rspValid_d = 1'b1;
            rspData_d  = loadData;
            state_d    = IDLE;
            if (op_q == OP_LR) begin
              resvValid_d = 1'b1;
              resvAddr_d  = addr_q;
            end
          end
        end else if (timeoutHit) begin
          rspValid_d = 1'b1;
          rspErr_d   = 2'b11;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      WR_ISSUE: begin
        busDv_d   = 1'b1;
        busWe_d   = 1'b1;
        busData_d = amoResult;
        timer_d   = '0;
        state_d   = WR_WAIT;
      end

      WR_WAIT: begin
        if (i_input_bus_DV) begin
          rspValid_d = 1'b1;
          rspData_d  = ((op_q >= OP_SWAP) && (op_q <= OP_MAXU)) ? oldRet : '0;
          state_d    = IDLE;
        end else if (timeoutHit) begin
          rspValid_d = 1'b1;
          rspErr_d   = 2'b11;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      old_q       <= '0;
      resvValid_q <= 1'b0;
      resvAddr_q  <= '0;
      timer_q     <= '0;
      rspValid_q  <= 1'b0;
      rspData_q   <= '0;
      rspErr_q    <= 2'b00;
      bhw_q       <= 4'b0000;
      busAddr_q   <= '0;
      busData_q   <= '0;
      busDv_q     <= 1'b0;
      busWe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      old_q       <= old_d;
      resvValid_q <= resvValid_d;
      resvAddr_q  <= resvAddr_d;
      timer_q     <= timer_d;
      rspValid_q  <= rspValid_d;
      rspData_q   <= rspData_d;
      rspErr_q    <= rspErr_d;
      bhw_q       <= bhw_d;
      busAddr_q   <= busAddr_d;
      busData_q   <= busData_d;
      busDv_q     <= busDv_d;
      busWe_q     <= busWe_d;
    end
  end

  assign o_req_ready     = (state_q == IDLE);
  assign o_rsp_valid     = rspValid_q;
  assign o_rsp_data      = rspData_q;
  assign o_rsp_err       = rspErr_q;
  assign o_bhw           = bhw_q;
  assign o_bus_address   = busAddr_q;
  assign o_bus_data      = busData_q;
  assign o_bus_DV        = busDv_q;
  assign o_write_notread = busWe_q;

endmodule

// File: tb/tb_lsu_amo_unit.sv
// Scoreboard bench for lsu_amo_unit: a bus memory responder services commands while a
// monitor pops expected responses and compares them against the unit's response pulses.
module tb_lsu_amo_unit;

  localparam int XLEN = 32;
  localparam int TOUT = 8;

  localparam logic [3:0] OP_LD = 4'd0, OP_ST = 4'd1, OP_LR = 4'd2, OP_SC = 4'd3;
  localparam logic [3:0] OP_SWAP = 4'd4, OP_ADD = 4'd5, OP_MAX = 4'd10;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic reqValid = 1'b0;
  logic [3:0] reqOp = '0;
  logic [1:0] reqSize = '0;
  logic reqSigned = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic inBusDv = 1'b0;
  logic [31:0] inBusData = '0;

  logic o_req_ready, o_rsp_valid, o_bus_DV, o_write_notread;
  logic [31:0] o_rsp_data, o_bus_address, o_bus_data;
  logic [1:0] o_rsp_err;
  logic [3:0] o_bhw;

  always #5 clk = ~clk;

  lsu_amo_unit #(.XLEN(XLEN), .TIMEOUT_CYC(TOUT), .LRSC_EN(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_req_valid(reqValid), .o_req_ready(o_req_ready),
    .i_req_op(reqOp), .i_req_size(reqSize), .i_req_signed(reqSigned),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_bhw(o_bhw), .o_bus_address(o_bus_address), .o_bus_data(o_bus_data),
    .o_bus_DV(o_bus_DV), .o_write_notread(o_write_notread),
    .i_input_bus_DV(inBusDv), .i_input_bus_data(inBusData)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [1:0]  err;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int checkCount = 0;
  int passCount = 0;
  int cmdCount = 0;
  int rspCount = 0;
  int busLat = 0;
  bit respEn = 1'b1;
  logic [31:0] mem [logic [31:0]];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] amoModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd4:    return b;
      4'd5:    return a + b;
      4'd6:    return a ^ b;
      4'd7:    return a & b;
      4'd8:    return a | b;
      4'd9:    return ($signed(a) < $signed(b)) ? a : b;
      4'd10:   return ($signed(a) > $signed(b)) ? a : b;
      4'd11:   return (a < b) ? a : b;
      4'd12:   return (a > b) ? a : b;
      default: return 32'h0;
    endcase
  endfunction

  // Memory model: every command is counted; when enabled it answers after busLat cycles.
  always begin : responder
    logic [31:0] a, d;
    logic we;
    @(negedge clk);
    if (rstN && o_bus_DV) begin
      cmdCount++;
      a = o_bus_address;
      d = o_bus_data;
      we = o_write_notread;
      if (respEn) begin
        repeat (busLat) @(negedge clk);
        if (we) mem[a] = d;
        inBusData = we ? 32'h0 : (mem.exists(a) ? mem[a] : 32'h0);
        inBusDv = 1'b1;
        @(negedge clk);
        inBusDv = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (o_rsp_valid) begin
      rspCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_rsp", o_rsp_valid, 0);
      end else begin
        monE = expQ.pop_front();
        checkOutput({monE.tag, "_data"}, o_rsp_data, monE.data);
        checkOutput({monE.tag, "_err"}, o_rsp_err, monE.err);
      end
    end
  end

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput({tag, "_rsp_missing"}, expQ.size(), 0);
      expQ.delete();
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input logic [1:0] expErr, input bit expectRsp);
    exp_t e;
    waitIdle(tag);
    checkOutput({tag, "_ready"}, o_req_ready, 1);
    reqOp = op;
    reqSize = size;
    reqSigned = sgn;
    reqAddr = addr;
    reqWdata = wdata;
    reqValid = 1'b1;
    if (expectRsp) begin
      e.tag = tag;
      e.data = expData;
      e.err = expErr;
      expQ.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int c0, r0, n;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", o_req_ready, 1);
    checkOutput("rst_rsp_valid", o_rsp_valid, 0);
    checkOutput("rst_rsp_data", o_rsp_data, 0);
    checkOutput("rst_bus_dv", o_bus_DV, 0);
    checkOutput("rst_bhw", o_bhw, 0);
    rstN = 1'b1;
    @(negedge clk);

    // Loads with sign/zero extension
    mem[32'h103] = 32'h000000F0;
    mem[32'h202] = 32'h00008001;
    mem[32'h300] = 32'h12345678;
    c0 = cmdCount;
    applyStimulus("lb", OP_LD, SZ_B, 1'b1, 32'h103, 0, 32'hFFFFFFF0, 2'b00, 1'b1);
    waitIdle("lb");
    checkOutput("lb_cmds", cmdCount - c0, 1);
    checkOutput("lb_bhw", o_bhw, 4'b0001);
    checkOutput("lb_wnr", o_write_notread, 0);
    applyStimulus("lbu", OP_LD, SZ_B, 1'b0, 32'h103, 0, 32'h000000F0, 2'b00, 1'b1);
    applyStimulus("lh", OP_LD, SZ_H, 1'b1, 32'h202, 0, 32'hFFFF8001, 2'b00, 1'b1);
    applyStimulus("lhu", OP_LD, SZ_H, 1'b0, 32'h202, 0, 32'h00008001, 2'b00, 1'b1);
    applyStimulus("lw", OP_LD, SZ_W, 1'b0, 32'h300, 0, 32'h12345678, 2'b00, 1'b1);

    // Store
    c0 = cmdCount;
    applyStimulus("sw", OP_ST, SZ_W, 1'b0, 32'h304, 32'hCAFEBABE, 0, 2'b00, 1'b1);
    waitIdle("sw");
    checkOutput("sw_mem", mem[32'h304], 32'hCAFEBABE);
    checkOutput("sw_cmds", cmdCount - c0, 1);
    checkOutput("sw_bhw", o_bhw, 4'b0100);
    checkOutput("sw_wnr", o_write_notread, 1);

    // Error reporting, illegal beats misaligned, no bus traffic
    c0 = cmdCount;
    applyStimulus("sh_mis", OP_ST, SZ_H, 1'b0, 32'h201, 32'h55, 0, 2'b01, 1'b1);
    applyStimulus("lw_mis", OP_LD, SZ_W, 1'b0, 32'h302, 0, 0, 2'b01, 1'b1);
    applyStimulus("bad_op", 4'd13, SZ_H, 1'b0, 32'h201, 0, 0, 2'b10, 1'b1);
    applyStimulus("bad_size", OP_LD, SZ_D, 1'b0, 32'h0, 0, 0, 2'b10, 1'b1);
    applyStimulus("amo_byte", OP_ADD, SZ_B, 1'b0, 32'h40, 1, 0, 2'b10, 1'b1);
    waitIdle("errs");
    checkOutput("errs_cmds", cmdCount - c0, 0);

    // AMOMAX with negative memory value
    mem[32'h40] = 32'hFFFFFFFE;
    c0 = cmdCount;
    applyStimulus("amomax", OP_MAX, SZ_W, 1'b0, 32'h40, 32'h5, 32'hFFFFFFFE, 2'b00, 1'b1);
    waitIdle("amomax");
    checkOutput("amomax_mem", mem[32'h40], 32'h5);
    checkOutput("amomax_cmds", cmdCount - c0, 2);
    checkOutput("amomax_addr", o_bus_address, 32'h40);

    // All nine AMOs against the model
    for (int i = 0; i < 9; i++) begin
      logic [3:0] op;
      logic [31:0] a, b, addr;
      op = OP_SWAP + 4'(i);
      a = (i >= 5) ? 32'hFFFFFFF0 : $urandom;
      b = (i >= 5) ? 32'h00000003 : $urandom;
      addr = 32'h400 + 32'(i * 4);
      mem[addr] = a;
      c0 = cmdCount;
      applyStimulus($sformatf("amo%0d", op), op, SZ_W, 1'b0, addr, b, a, 2'b00, 1'b1);
      waitIdle("amo");
      checkOutput($sformatf("amo%0d_mem", op), mem[addr], amoModel(op, a, b));
      checkOutput($sformatf("amo%0d_cmds", op), cmdCount - c0, 2);
    end

    // LR/SC reservation
    mem[32'h80] = 32'h11;
    applyStimulus("lr", OP_LR, SZ_W, 1'b0, 32'h80, 0, 32'h11, 2'b00, 1'b1);
    c0 = cmdCount;
    applyStimulus("sc_pass", OP_SC, SZ_W, 1'b0, 32'h80, 32'h7, 0, 2'b00, 1'b1);
    waitIdle("sc_pass");
    checkOutput("sc_pass_mem", mem[32'h80], 32'h7);
    checkOutput("sc_pass_cmds", cmdCount - c0, 1);
    c0 = cmdCount;
    applyStimulus("sc_again", OP_SC, SZ_W, 1'b0, 32'h80, 32'h9, 1, 2'b00, 1'b1);
    waitIdle("sc_again");
    checkOutput("sc_again_cmds", cmdCount - c0, 0);
    checkOutput("sc_again_mem", mem[32'h80], 32'h7);
    applyStimulus("lr2", OP_LR, SZ_W, 1'b0, 32'h90, 0, 0, 2'b00, 1'b1);
    applyStimulus("st_clr", OP_ST, SZ_W, 1'b0, 32'h90, 32'h3, 0, 2'b00, 1'b1);
    applyStimulus("sc_clr", OP_SC, SZ_W, 1'b0, 32'h90, 32'h4, 1, 2'b00, 1'b1);
    applyStimulus("lr3", OP_LR, SZ_W, 1'b0, 32'hA0, 0, 0, 2'b00, 1'b1);
    applyStimulus("sc_other", OP_SC, SZ_W, 1'b0, 32'hA4, 32'h4, 1, 2'b00, 1'b1);

    // Watchdog: no bus reply
    respEn = 1'b0;
    c0 = cmdCount;
    applyStimulus("tout", OP_LD, SZ_W, 1'b0, 32'h500, 0, 0, 2'b11, 1'b1);
    n = 0;
    while (!o_rsp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tout_cycles", n, TOUT);
    waitIdle("tout");
    checkOutput("tout_cmds", cmdCount - c0, 1);
    respEn = 1'b1;

    // Reset while the AMOADD write is outstanding
    busLat = 3;
    mem[32'h600] = 32'd10;
    applyStimulus("rstamo", OP_ADD, SZ_W, 1'b0, 32'h600, 32'd5, 0, 2'b00, 1'b0);
    n = 0;
    while (!(o_bus_DV && o_write_notread) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rstamo_wr_issued", o_bus_DV & o_write_notread, 1);
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("rstamo_ready", o_req_ready, 1);
    checkOutput("rstamo_rsp_valid", o_rsp_valid, 0);
    checkOutput("rstamo_bus_dv", o_bus_DV, 0);
    checkOutput("rstamo_bus_addr", o_bus_address, 0);
    checkOutput("rstamo_bus_data", o_bus_data, 0);
    checkOutput("rstamo_wnr", o_write_notread, 0);
    r0 = rspCount;
    rstN = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("rstamo_no_rsp", rspCount - r0, 0);
    checkOutput("rstamo_idle", o_req_ready, 1);
    busLat = 0;

    applyStimulus("lw_after", OP_LD, SZ_W, 1'b0, 32'h300, 0, 32'h12345678, 2'b00, 1'b1);
    waitIdle("end");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
